// File: rtl/flght_pkg.sv
// Shared definitions for the flight sequencer: state encodings, default
// timing parameters and the thrust step helper.
package flght_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAL   = 3'd1,
        ST_READY = 3'd2,
        ST_FLY   = 3'd3,
        ST_LAND  = 3'd4,
        ST_FAULT = 3'd5
    } flght_state_e;

    localparam int CAL_TIMEOUT_DEF = 65536;
    localparam int VLD_TIMEOUT_DEF = 1024;
    localparam int RAMP_DIV_DEF    = 256;
    localparam int THRST_W         = 9;

    // One step toward the target; never passes it and never wraps.
    function automatic logic [THRST_W-1:0] step_toward(
        input logic [THRST_W-1:0] cur,
        input logic [THRST_W-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + 9'd1;
        end
        if (cur > tgt) begin
            return cur - 9'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/flght_wdog.sv
// Inactivity watchdog: expires when TIMEOUT consecutive cycles pass without
// a kick while not held in clear. A kick in the final cycle still rescues it.
module flght_wdog
    import flght_pkg::*;
#(
    parameter int TIMEOUT = VLD_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic kick,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_reg;

    assign expired = !clr && !kick && (cnt_reg == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || kick) begin
            cnt_reg <= '0;
        end else if (!expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/flght_seq.sv
// Flight sequencer: calibration, arming, rate-limited thrust ramp, landing
// and latched fault handling. All outputs come straight from registers.
module flght_seq
    import flght_pkg::*;
#(
    parameter int CAL_TIMEOUT = CAL_TIMEOUT_DEF,
    parameter int VLD_TIMEOUT = VLD_TIMEOUT_DEF,
    parameter int RAMP_DIV    = RAMP_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                strt_cal,
    input  logic                cal_done,
    input  logic                arm,
    input  logic                disarm,
    input  logic                vld,
    input  logic [THRST_W-1:0]  thrst_cmd,
    output logic                inertial_cal,
    output logic [THRST_W-1:0]  thrst,
    output logic                motors_en,
    output logic                fault,
    output logic [2:0]          state
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] CAL   = ST_CAL;
    localparam logic [2:0] READY = ST_READY;
    localparam logic [2:0] FLY   = ST_FLY;
    localparam logic [2:0] LAND  = ST_LAND;
    localparam logic [2:0] FAULT = ST_FAULT;

    localparam int CW = (CAL_TIMEOUT > 1) ? $clog2(CAL_TIMEOUT) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [2:0]         state_reg, state_next;
    logic               fault_reg, fault_next;
    logic [THRST_W-1:0] thrst_reg, thrst_next;
    logic [CW-1:0]      cal_cnt_reg, cal_cnt_next;
    logic [RW-1:0]      tick_reg, tick_next;
    logic               motors_en_reg, inertial_cal_reg;

    logic               wdog_expired;
    logic               cal_expired;
    logic               tick_wrap;
    logic               ramping_next;
    logic [THRST_W-1:0] target;

    flght_wdog #(
        .TIMEOUT (VLD_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_reg != FLY),
        .kick    (vld),
        .expired (wdog_expired)
    );

    assign cal_expired = (state_reg == CAL) && (cal_cnt_reg == CW'(CAL_TIMEOUT - 1));
    assign tick_wrap   = ((state_reg == FLY) || (state_reg == LAND)) &&
                         (tick_reg == RW'(RAMP_DIV - 1));

    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        case (state_reg)
            IDLE: begin
                if (strt_cal) begin
                    state_next = CAL;
                end
            end
            CAL: begin
                if (cal_done) begin
                    state_next = READY;
                end else if (cal_expired) begin
                    state_next = FAULT;
                    fault_next = 1'b1;
                end
            end
            READY: begin
                if (disarm) begin
                    state_next = READY;
                end else if (arm) begin
                    state_next = FLY;
                end else if (strt_cal) begin
                    state_next = CAL;
                end
            end
            FLY: begin
                if (wdog_expired) begin
                    state_next = LAND;
                    fault_next = 1'b1;
                end else if (disarm) begin
                    state_next = LAND;
                end
            end
            LAND: begin
                if (thrst_reg == '0) begin
                    state_next = fault_reg ? FAULT : IDLE;
                end
            end
            FAULT: begin
                fault_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The ramp tick restarts whenever the ramping state is (re)entered.
    always_comb begin
        ramping_next = (state_next == FLY) || (state_next == LAND);
        tick_next    = '0;
        if (ramping_next && (state_next == state_reg)) begin
            tick_next = tick_wrap ? '0 : tick_reg + 1'b1;
        end

        cal_cnt_next = '0;
        if ((state_reg == CAL) && (state_next == CAL)) begin
            cal_cnt_next = cal_cnt_reg + 1'b1;
        end

        // Leaving flight for landing retargets the ramp at zero immediately.
        target     = (state_next == FLY) ? thrst_cmd : '0;
        thrst_next = thrst_reg;
        if (tick_wrap) begin
            thrst_next = step_toward(thrst_reg, target);
        end
        if (!ramping_next) begin
            thrst_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            fault_reg        <= 1'b0;
            thrst_reg        <= '0;
            cal_cnt_reg      <= '0;
            tick_reg         <= '0;
            motors_en_reg    <= 1'b0;
            inertial_cal_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            fault_reg        <= fault_next;
            thrst_reg        <= thrst_next;
            cal_cnt_reg      <= cal_cnt_next;
            tick_reg         <= tick_next;
            motors_en_reg    <= (state_next == CAL) || ramping_next;
            inertial_cal_reg <= (state_next == CAL);
        end
    end

    assign state        = state_reg;
    assign fault        = fault_reg;
    assign thrst        = thrst_reg;
    assign motors_en    = motors_en_reg;
    assign inertial_cal = inertial_cal_reg;

endmodule

// File: tb/tb_flght_seq.sv
// Scenario bench for flght_seq with short timeouts; per-cycle expectations
// are queued as stimulus is driven and popped after each clock edge.
module tb_flght_seq;

    localparam int CAL_T = 32;
    localparam int VLD_T = 16;
    localparam int RDIV  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strt_cal = 1'b0;
    logic       cal_done = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       vld = 1'b0;
    logic [8:0] thrst_cmd = '0;
    logic       inertial_cal;
    logic [8:0] thrst;
    logic       motors_en;
    logic       fault;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    logic [14:0] exp_q[$];
    logic [14:0] obs;

    assign obs = {state, thrst, motors_en, inertial_cal, fault};

    always #5 clk = ~clk;

    flght_seq #(
        .CAL_TIMEOUT (CAL_T),
        .VLD_TIMEOUT (VLD_T),
        .RAMP_DIV    (RDIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .strt_cal     (strt_cal),
        .cal_done     (cal_done),
        .arm          (arm),
        .disarm       (disarm),
        .vld          (vld),
        .thrst_cmd    (thrst_cmd),
        .inertial_cal (inertial_cal),
        .thrst        (thrst),
        .motors_en    (motors_en),
        .fault        (fault),
        .state        (state)
    );

    function automatic logic [14:0] pk(int st, int th, bit me, bit ic, bit f);
        return {3'(st), 9'(th), me, ic, f};
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        strt_cal  = 1'b0;
        cal_done  = 1'b0;
        arm       = 1'b0;
        disarm    = 1'b0;
        vld       = 1'b0;
        thrst_cmd = '0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic go_ready();
        strt_cal = 1'b1;
        cyc();
        strt_cal = 1'b0;
        cal_done = 1'b1;
        cyc();
        cal_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        #1;
        exp_q.push_back(pk(0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_async got=%h required=%h", obs, e);
        end
        cyc();
        rst_n = 1'b1;
        exp_q.push_back(pk(0, 0, 0, 0, 0));
        cyc();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_idle got=%h required=%h", obs, e);
        end
        $display("scenario reset done");
    endtask

    task automatic test_cal_ok();
        logic [14:0] e;
        for (int n = 1; n <= 11; n++) begin
            strt_cal = (n == 1);
            cal_done = (n == 11);
            exp_q.push_back((n < 11) ? pk(1, 0, 1, 1, 0) : pk(2, 0, 0, 0, 0));
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL cal_ok n=%0d got st=%0d th=%0d me=%0b ic=%0b f=%0b required st=%0d th=%0d me=%0b ic=%0b f=%0b",
                         n, obs[14:12], obs[11:3], obs[2], obs[1], obs[0],
                         e[14:12], e[11:3], e[2], e[1], e[0]);
            end
        end
        clear_inputs();
        $display("scenario cal_ok done");
    endtask

    task automatic test_cal_timeout();
        logic [14:0] e;
        for (int n = 1; n <= 36; n++) begin
            strt_cal = (n == 1) || (n == 36);
            arm      = (n == 35);
            exp_q.push_back((n <= 32) ? pk(1, 0, 1, 1, 0) : pk(5, 0, 0, 0, 1));
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL cal_timeout n=%0d got st=%0d th=%0d me=%0b ic=%0b f=%0b required st=%0d th=%0d me=%0b ic=%0b f=%0b",
                         n, obs[14:12], obs[11:3], obs[2], obs[1], obs[0],
                         e[14:12], e[11:3], e[2], e[1], e[0]);
            end
        end
        clear_inputs();
        hard_reset();
        $display("scenario cal_timeout done");
    endtask

    task automatic test_cal_tie();
        logic [14:0] e;
        for (int n = 1; n <= 34; n++) begin
            strt_cal = (n == 1);
            cal_done = (n == 33);
            exp_q.push_back((n < 33) ? pk(1, 0, 1, 1, 0) : pk(2, 0, 0, 0, 0));
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL cal_tie n=%0d got st=%0d f=%0b required st=%0d f=%0b",
                         n, obs[14:12], obs[0], e[14:12], e[0]);
            end
        end
        clear_inputs();
        $display("scenario cal_tie done");
    endtask

    task automatic test_ramp();
        logic [14:0] e;
        int th;
        thrst_cmd = 9'd5;
        for (int n = 1; n <= 42; n++) begin
            arm = (n == 1);
            vld = (n % 8 == 0);
            if (n == 31) thrst_cmd = 9'd3;
            if (n <= 30) th = imin(5, (n - 1) / 4);
            else if (n < 33) th = 5;
            else th = (5 - (n - 29) / 4 < 3) ? 3 : 5 - (n - 29) / 4;
            exp_q.push_back(pk(3, th, 1, 0, 0));
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL ramp n=%0d got st=%0d th=%0d me=%0b required st=%0d th=%0d me=%0b",
                         n, obs[14:12], obs[11:3], obs[2], e[14:12], e[11:3], e[2]);
            end
        end
        vld = 1'b0;
        // asynchronous reset between clock edges, mid-flight
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pk(0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_mid_fly got=%h required=%h", obs, e);
        end
        clear_inputs();
        cyc();
        rst_n = 1'b1;
        $display("scenario ramp done");
    endtask

    task automatic test_wdog();
        logic [14:0] e;
        go_ready();
        thrst_cmd = 9'd3;
        for (int n = 1; n <= 48; n++) begin
            arm = (n == 1);
            vld = (n == 2) || (n == 18);
            if (n <= 33) e = pk(3, imin(3, (n - 1) / 4), 1, 0, 0);
            else if (n <= 46) e = pk(4, 3 - (n - 34) / 4, 1, 0, 1);
            else e = pk(5, 0, 0, 0, 1);
            exp_q.push_back(e);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL wdog n=%0d got st=%0d th=%0d me=%0b f=%0b required st=%0d th=%0d me=%0b f=%0b",
                         n, obs[14:12], obs[11:3], obs[2], obs[0],
                         e[14:12], e[11:3], e[2], e[0]);
            end
        end
        hard_reset();
        $display("scenario wdog done");
    endtask

    task automatic test_disarm();
        logic [14:0] e;
        go_ready();
        thrst_cmd = 9'd2;
        for (int n = 1; n <= 21; n++) begin
            arm      = (n == 1) || (n == 16);
            disarm   = (n == 11);
            strt_cal = (n == 17);
            vld      = (n % 4 == 0);
            if (n <= 10) e = pk(3, imin(2, (n - 1) / 4), 1, 0, 0);
            else if (n <= 19) e = pk(4, 2 - (n - 11) / 4, 1, 0, 0);
            else e = pk(0, 0, 0, 0, 0);
            exp_q.push_back(e);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL disarm n=%0d got st=%0d th=%0d me=%0b f=%0b required st=%0d th=%0d me=%0b f=%0b",
                         n, obs[14:12], obs[11:3], obs[2], obs[0],
                         e[14:12], e[11:3], e[2], e[0]);
            end
        end
        clear_inputs();
        $display("scenario disarm done");
    endtask

    task automatic test_arm_disarm();
        logic [14:0] e;
        go_ready();
        for (int n = 1; n <= 5; n++) begin
            arm      = (n == 1) || (n == 3);
            disarm   = (n == 1) || (n == 2) || (n == 4);
            strt_cal = (n == 2);
            case (n)
                1, 2:    e = pk(2, 0, 0, 0, 0);
                3:       e = pk(3, 0, 1, 0, 0);
                4:       e = pk(4, 0, 1, 0, 0);
                default: e = pk(0, 0, 0, 0, 0);
            endcase
            exp_q.push_back(e);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL arm_disarm n=%0d got st=%0d me=%0b required st=%0d me=%0b",
                         n, obs[14:12], obs[2], e[14:12], e[2]);
            end
        end
        clear_inputs();
        $display("scenario arm_disarm done");
    endtask

    initial begin
        test_reset();
        test_cal_ok();
        test_cal_timeout();
        test_cal_tie();
        test_ramp();
        test_wdog();
        test_disarm();
        test_arm_disarm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flght_seq.md
FLGHT_SEQ -- requirements
Module: flght_seq

Interface

- REQ-001 The block SHALL have parameter CAL_TIMEOUT, default 65536: max clk cycles in CAL before a fault.
- REQ-002 The block SHALL have parameter VLD_TIMEOUT, default 1024: max clk cycles between vld pulses in FLY.
- REQ-003 The block SHALL have parameter RAMP_DIV, default 256: clk cycles per single thrust step.
- REQ-004 The block SHALL have port clk, input, 1 bit: clock.
- REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 The block SHALL have port strt_cal, input, 1 bit: pulse requesting inertial calibration.
- REQ-007 The block SHALL have port cal_done, input, 1 bit: pulse from the inertial interface signalling calibration complete.
- REQ-008 The block SHALL have ports arm and disarm, input, 1 bit each: operator pulses.
- REQ-009 The block SHALL have port vld, input, 1 bit: new inertial reading strobe.
- REQ-010 The block SHALL have port thrst_cmd, input, 9 bits unsigned: requested thrust from the slider.
- REQ-011 The block SHALL have port inertial_cal, output, 1 bit: drives the flight controller into CAL_SPEED mode.
- REQ-012 The block SHALL have port thrst, output, 9 bits unsigned: rate-limited thrust to the flight controller.
- REQ-013 The block SHALL have port motors_en, output, 1 bit: ESC enable.
- REQ-014 The block SHALL have port fault, output, 1 bit: latched fault flag.
- REQ-015 The block SHALL have port state, output, 3 bits: current FSM state.

Function

- REQ-016 The FSM SHALL have these states and encodings: IDLE=0, CAL=1, READY=2, FLY=3, LAND=4, FAULT=5. Transitions SHALL be registered, so a change is visible the cycle after the input is sampled.
- REQ-017 IDLE: inertial_cal=0, motors_en=0, thrst=0; strt_cal SHALL move the FSM to CAL.
- REQ-018 CAL: inertial_cal=1, motors_en=1, thrst=0.
  - cal_done SHALL move the FSM to READY.
  - If the cal timer reaches CAL_TIMEOUT, the FSM SHALL set fault and go to FAULT.
  - If cal_done and the timeout occur in the same cycle, cal_done SHALL win.
- REQ-019 READY: motors_en=0, thrst=0.
  - arm SHALL move the FSM to FLY.
  - strt_cal SHALL move the FSM to CAL.
  - disarm has priority over arm and strt_cal in the same cycle (FSM stays in READY).
- REQ-020 FLY: motors_en=1, inertial_cal=0, thrst ramps toward thrst_cmd.
  - disarm SHALL move the FSM to LAND.
  - Watchdog expiry SHALL set fault and move the FSM to LAND.
- REQ-021 Ramp: a tick counter counts 0..RAMP_DIV-1, wraps, and is cleared on entry to FLY or LAND.
  - On each wrap, thrst SHALL step +1 if below target, -1 if above, and hold if equal.
  - thrst SHALL never overshoot the target.
- REQ-022 LAND: target is 0 and thrst decrements per REQ-021.
  - When thrst==0, the FSM SHALL go to FAULT if fault is set, else to IDLE.
  - arm and strt_cal SHALL be ignored in LAND.
- REQ-023 FAULT: motors_en=0, thrst=0, inertial_cal=0, fault=1. FAULT SHALL be exited only by rst_n.
- REQ-024 Watchdog: the counter SHALL clear on entry to FLY and on every vld, and increment otherwise while in FLY. Expiry SHALL occur when the count equals VLD_TIMEOUT-1 with no vld that cycle. A vld in the expiry cycle SHALL prevent expiry.
- REQ-025 The cal timer SHALL clear on entry to CAL and count only in CAL.
- REQ-026 All outputs SHALL be registered (Moore); thrst SHALL only be non-zero in FLY or LAND.
- REQ-027 Counter widths SHALL be $clog2 of the respective parameter. thrst arithmetic SHALL be 9-bit unsigned with no wrap at 0 or 511.

Reset

- REQ-028 On rst_n low, the block SHALL asynchronously force: state=IDLE, thrst=0, motors_en=0, inertial_cal=0, fault=0, all counters=0.
- REQ-029 Reset asserted mid-FLY SHALL drop thrst to 0 immediately, with no landing ramp.

Structure

- REQ-030 A shared package flght_pkg SHALL hold the state enum and the default CAL_TIMEOUT, VLD_TIMEOUT and RAMP_DIV constants.
- REQ-031 The watchdog SHALL be a sub-module flght_wdog (inputs: clr, kick; output: expired), instantiated once for vld.

Verification (RAMP_DIV=4, VLD_TIMEOUT=16, CAL_TIMEOUT=32)

- REQ-032 strt_cal, then cal_done 10 cycles later: state 0->1->2, inertial_cal=1 during CAL only, fault=0.
- REQ-033 CAL with no cal_done: state=5 and fault=1 after 32 cycles in CAL, motors_en=0.
- REQ-034 READY, arm, thrst_cmd=5, vld every 8 cycles: thrst steps 0,1,2,3,4,5 at 4-cycle spacing, then holds at 5.
- REQ-035 FLY at thrst=3, vld withheld 16 cycles: fault=1, state=4, thrst falls 3->0 over 12 cycles, then state=5.
- REQ-036 FLY at thrst=2, disarm: LAND, thrst reaches 0, state=0, fault=0.
- REQ-037 READY with arm and disarm in the same cycle: state stays 2. Separately, rst_n pulsed mid-FLY: all outputs 0 and state=0 asynchronously.
